// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronizes and glitch-filters A/B, emits one-cycle step pulses
// with a direction level, and flags illegal double transitions. Filter enabled by QDEC_FILTER_EN.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a_in,
  input  logic b_in,
  input  logic err_clr,
  output logic step_en,
  output logic step_dir,
  output logic illegal,
  output logic err_sticky
);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  localparam logic [1:0] MV_NONE = 2'd0;
  localparam logic [1:0] MV_UP   = 2'd1;
  localparam logic [1:0] MV_DOWN = 2'd2;
  localparam logic [1:0] MV_ILL  = 2'd3;

`ifdef QDEC_FILTER_EN
  localparam int SETTLE_LEN = SYNC_STAGES + FILTER_LEN;
`else
  // FILTER_LEN has no effect without the filter
  localparam int SETTLE_LEN = SYNC_STAGES + (FILTER_LEN * 0);
`endif
  localparam int SET_W = $clog2(SETTLE_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_a_r, sync_b_r;
  logic                   s_a_s, s_b_s, fa_s, fb_s;
  logic [1:0]             cur_s, init_ab_s, move_s, prev_r;
  logic [0:0]             state_r;
  logic [SET_W-1:0]       settle_r;
  logic                   step_en_r, step_dir_r, illegal_r, err_sticky_r;
  logic                   illegal_evt_s;

  // synchronizer chains for both channels
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_r <= '0;
      sync_b_r <= '0;
    end else begin
      sync_a_r <= {sync_a_r[SYNC_STAGES-2:0], a_in};
      sync_b_r <= {sync_b_r[SYNC_STAGES-2:0], b_in};
    end
  end

  assign s_a_s = sync_a_r[SYNC_STAGES-1];
  assign s_b_s = sync_b_r[SYNC_STAGES-1];

`ifdef QDEC_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             fa_r, fb_r;
  logic [CNT_W-1:0] cnt_a_r, cnt_b_r;

  // per-channel hold filter; bypassed while settling so f starts at the real input level
  always_ff @(posedge clk) begin
    if (rst || (state_r == ST_INIT)) begin
      fa_r    <= rst ? 1'b0 : s_a_s;
      fb_r    <= rst ? 1'b0 : s_b_s;
      cnt_a_r <= '0;
      cnt_b_r <= '0;
    end else begin
      if (s_a_s == fa_r) begin
        cnt_a_r <= '0;
      end else if (cnt_a_r == CNT_W'(FILTER_LEN - 1)) begin
        fa_r    <= s_a_s;
        cnt_a_r <= '0;
      end else begin
        cnt_a_r <= cnt_a_r + CNT_W'(1);
      end
      if (s_b_s == fb_r) begin
        cnt_b_r <= '0;
      end else if (cnt_b_r == CNT_W'(FILTER_LEN - 1)) begin
        fb_r    <= s_b_s;
        cnt_b_r <= '0;
      end else begin
        cnt_b_r <= cnt_b_r + CNT_W'(1);
      end
    end
  end

  assign fa_s      = fa_r;
  assign fb_s      = fb_r;
  assign init_ab_s = {fa_r, fb_r};
`else
  assign fa_s      = s_a_s;
  assign fb_s      = s_b_s;
  // f is combinational here, so prev tracks the value s takes on the next edge
  assign init_ab_s = {sync_a_r[SYNC_STAGES-2], sync_b_r[SYNC_STAGES-2]};
`endif

  assign cur_s = {fa_s, fb_s};

  // classify the transition prev -> cur
  always_comb begin
    move_s = MV_ILL;
    case ({prev_r, cur_s})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: move_s = MV_UP;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: move_s = MV_DOWN;
      4'b0000, 4'b0101, 4'b1010, 4'b1111: move_s = MV_NONE;
      default:                            move_s = MV_ILL;
    endcase
  end

  assign illegal_evt_s = (state_r == ST_TRACK) && (move_s == MV_ILL);

  // settle/track FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_INIT;
      settle_r     <= '0;
      prev_r       <= 2'b00;
      step_en_r    <= 1'b0;
      step_dir_r   <= 1'b1;
      illegal_r    <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      step_en_r <= 1'b0;
      illegal_r <= 1'b0;
      case (state_r)
        ST_INIT: begin
          prev_r <= init_ab_s;
          if (settle_r == SET_W'(SETTLE_LEN - 1)) begin
            state_r  <= ST_TRACK;
            settle_r <= '0;
          end else begin
            settle_r <= settle_r + SET_W'(1);
          end
        end
        ST_TRACK: begin
          prev_r <= cur_s;
          case (move_s)
            MV_UP: begin
              step_en_r  <= en;
              step_dir_r <= 1'b1;
            end
            MV_DOWN: begin
              step_en_r  <= en;
              step_dir_r <= 1'b0;
            end
            MV_ILL:  illegal_r <= 1'b1;
            default: step_en_r <= 1'b0;
          endcase
        end
        default: begin
          state_r  <= ST_INIT;
          settle_r <= '0;
        end
      endcase
      // set has priority over clear
      if (illegal_evt_s) begin
        err_sticky_r <= 1'b1;
      end else if (err_clr) begin
        err_sticky_r <= 1'b0;
      end else begin
        err_sticky_r <= err_sticky_r;
      end
    end
  end

  assign step_en    = step_en_r;
  assign step_dir   = step_dir_r;
  assign illegal    = illegal_r;
  assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed self-checking bench for quad_step_decoder; models a 4-bit up/down counter downstream.
module tb_quad_step_decoder;

`ifdef QDEC_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst, en, a_in, b_in, err_clr;
  logic step_en, step_dir, illegal, err_sticky;

  int checks = 0;
  int errors = 0;

  logic [3:0] ctr;
  logic       wrap_seen;

  quad_step_decoder #(.SYNC_STAGES(2), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
    .step_en(step_en), .step_dir(step_dir), .illegal(illegal), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // downstream updown_counter model
  always @(posedge clk) begin
    if (rst) begin
      ctr       <= 4'd0;
      wrap_seen <= 1'b0;
    end else if (step_en) begin
      if (step_dir) begin
        ctr <= ctr + 4'd1;
        if (ctr == 4'd15) wrap_seen <= 1'b1;
      end else begin
        ctr <= ctr - 4'd1;
        if (ctr == 4'd0) wrap_seen <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive {a,b} at a negedge and observe for n cycles
  task automatic drive_ab(input logic [1:0] ab, input int n,
                          output int pulses, output int first, output int ills);
    {a_in, b_in} = ab;
    pulses = 0; first = 0; ills = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); @(negedge clk);
      if (step_en === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
      if (illegal === 1'b1) ills++;
    end
  endtask

  initial begin
    int p, f, il, p2, f2, il2;
    logic [1:0] up_seq [4];
    logic [1:0] dn_seq [4];
    up_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    dn_seq = '{2'b10, 2'b11, 2'b01, 2'b00};

    // test 1: reset with inputs at 11
    rst = 1'b1; en = 1'b1; err_clr = 1'b0; a_in = 1'b1; b_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_step_en", step_en, 1'b0);
    chk("rst_step_dir", step_dir, 1'b1);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_err", err_sticky, 1'b0);
    rst = 1'b0;
    drive_ab(2'b11, 10, p, f, il);
    chk("t1_pulses", p, 0);
    chk("t1_illegal", il, 0);
    chk("t1_dir", step_dir, 1'b1);
    chk("t1_err", err_sticky, 1'b0);

    // test 2: up sequence from 00
    rst = 1'b1; a_in = 1'b0; b_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_ab(2'b00, 10, p, f, il);
    chk("t2_idle_pulses", p, 0);
    for (int k = 0; k < 4; k++) begin
      drive_ab(up_seq[k], 8, p, f, il);
      chk("t2_up_pulses", p, 1);
      chk("t2_up_latency", f, LAT);
      chk("t2_up_dir", step_dir, 1'b1);
      chk("t2_up_illegal", il, 0);
    end
    chk("t2_ctr", ctr, 4'd4);

    // test 3: down sequence, then one more down to wrap
    for (int k = 0; k < 4; k++) begin
      drive_ab(dn_seq[k], 8, p, f, il);
      chk("t3_dn_pulses", p, 1);
      chk("t3_dn_latency", f, LAT);
      chk("t3_dn_dir", step_dir, 1'b0);
    end
    chk("t3_ctr", ctr, 4'd0);
    chk("t3_nowrap", wrap_seen, 1'b0);
    drive_ab(2'b10, 8, p, f, il);
    chk("t3_wrap_pulses", p, 1);
    chk("t3_wrap_ctr", ctr, 4'd15);
    chk("t3_wrap_flag", wrap_seen, 1'b1);
    drive_ab(2'b00, 8, p, f, il);
    chk("t3_back_up", p, 1);
    chk("t3_back_dir", step_dir, 1'b1);

`ifdef QDEC_FILTER_EN
    // test 4: 3-cycle glitch rejected, 4-cycle pulse accepted
    drive_ab(2'b10, 3, p, f, il);
    drive_ab(2'b00, 10, p2, f2, il2);
    chk("t4_glitch3", p + p2, 0);
    drive_ab(2'b10, 4, p, f, il);
    drive_ab(2'b00, 5, p2, f2, il2);
    chk("t4_hold4_rise", p + p2, 1);
    chk("t4_hold4_dir", step_dir, 1'b0);
    drive_ab(2'b00, 6, p, f, il);
    chk("t4_hold4_fall", p, 1);
    chk("t4_fall_dir", step_dir, 1'b1);
`endif

    // test 5: illegal jump, clear, then clear colliding with a second illegal
    drive_ab(2'b11, 8, p, f, il);
    chk("t5_ill_pulses", il, 1);
    chk("t5_ill_latency_steps", p, 0);
    chk("t5_err_set", err_sticky, 1'b1);
    chk("t5_dir_held", step_dir, 1'b1);
    err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
    chk("t5_err_cleared", err_sticky, 1'b0);
    drive_ab(2'b00, LAT - 1, p, f, il);
    chk("t5_ill_early", il, 0);
    err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
    chk("t5_ill2", illegal, 1'b1);
    chk("t5_set_wins", err_sticky, 1'b1);
    drive_ab(2'b00, 4, p, f, il);
    chk("t5_no_steps", p, 0);

    // test 6: en=0 tracks direction without pulses, no burst on re-enable
    drive_ab(2'b10, 8, p, f, il);
    chk("t6_down_pulse", p, 1);
    chk("t6_down_dir", step_dir, 1'b0);
    en = 1'b0;
    drive_ab(2'b00, 8, p, f, il);
    drive_ab(2'b01, 8, p2, f2, il2);
    chk("t6_disabled_pulses", p + p2, 0);
    chk("t6_disabled_dir", step_dir, 1'b1);
    en = 1'b1;
    drive_ab(2'b01, 10, p, f, il);
    chk("t6_no_burst", p, 0);
    drive_ab(2'b11, 8, p, f, il);
    chk("t6_reenabled_pulse", p, 1);
    chk("t6_reenabled_latency", f, LAT);
    chk("t6_err_still_set", err_sticky, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
